xor_stream_descrambler: RTL and testbench
=========================================

XOR_STREAM_DESCRAMBLER -- requirements
Module: xor_stream_descrambler

Interface
REQ-001 The block SHALL have one clock and one reset, both listed first in the port list; reset SHALL be synchronous and active-high.
REQ-002 Parameter: SEED_DEFAULT, 16'hACE1, the LFSR value after reset and the value substituted for any zero seed.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: seed_load  input  1  when high, loads seed into the LFSR this cycle.
REQ-006 Port: seed  input  16  new LFSR value, sampled only when seed_load=1.
REQ-007 Port: in_valid  input  1  in_data holds a scrambled word.
REQ-008 Port: in_ready  output  1  the block can accept a word this cycle.
REQ-009 Port: in_data  input  16  scrambled input word.
REQ-010 Port: out_valid  output  1  out_data holds a descrambled word.
REQ-011 Port: out_ready  input  1  the downstream stage takes out_data this cycle.
REQ-012 Port: out_data  output  16  descrambled word.
REQ-013 Port: word_cnt  output  8  count of words accepted since the last reset or seed load.

Function
REQ-014 The LFSR SHALL be a 16-bit Fibonacci register with polynomial x^16+x^14+x^13+x^11+1.
- fb = s[15]^s[13]^s[12]^s[10]
- next = {s[14:0], fb}
REQ-015 A word is accepted when in_valid && in_ready in the same cycle (an "accept").
REQ-016 On an accept, the block SHALL, at the next clock edge:
- out_data <= in_data ^ s, where s is the current LFSR value
- LFSR <= next
- out_valid <= 1
- word_cnt <= word_cnt+1
REQ-017 Latency from accept to out_valid SHALL be exactly 1 cycle.
REQ-018 in_ready SHALL be combinational: in_ready = !seed_load && (!out_valid || out_ready).
REQ-019 A simultaneous output take and new accept SHALL sustain full throughput: out_valid stays 1 and out_data takes the new word.
REQ-020 If out_ready=1 with out_valid=1 and there is no accept, out_valid SHALL go to 0 at the next edge.
REQ-021 While out_valid=1 && out_ready=0, out_data and out_valid SHALL hold stable.
REQ-022 The LFSR SHALL advance only on an accept; idle cycles and stalled cycles SHALL NOT advance it.
REQ-023 On seed_load=1:
- LFSR <= seed, or SEED_DEFAULT if seed==0
- word_cnt <= 0
- no accept occurs that cycle
- the out_valid/out_data register is unaffected, so a pending output word is preserved and may still be taken
REQ-024 word_cnt SHALL wrap from 8'hFF to 8'h00 without any other side effect.
REQ-025 The LFSR SHALL never hold 16'h0000.

Reset
REQ-026 When rst=1 at a clock edge, the block SHALL set:
- LFSR = SEED_DEFAULT
- out_valid = 0
- out_data = 16'h0000
- word_cnt = 0
REQ-027 rst SHALL take priority over seed_load and over any accept in the same cycle.
REQ-028 rst asserted mid-stream SHALL drop any pending output word.
REQ-029 The first word after reset SHALL be descrambled with SEED_DEFAULT.
REQ-030 in_ready SHALL be 1 in the first cycle after reset if seed_load=0.

Verification
REQ-031 Reset, then in_data=16'hAAAA accepted with out_ready=1 -> next cycle out_valid=1, out_data=16'h064B, word_cnt=1.
REQ-032 Second word in_data=16'h00FF on the following cycle -> out_data=16'h593C (LFSR 16'h59C3), word_cnt=2; back-to-back accepts with no bubble.
REQ-033 Hold out_ready=0 after one accept:
- in_ready=0 and out_data is stable for 5 cycles
- the LFSR does not advance
- raising out_ready together with in_valid -> the new word is accepted in the same cycle
REQ-034 seed_load=1 with seed=16'h0000, then accept 16'hAAAA -> out_data=16'h064B, word_cnt=1.
REQ-035 seed_load=1 while a word is pending -> the pending out_data is preserved, in_ready=0 that cycle, word_cnt=0 afterwards.
REQ-036 256 accepts after reset -> word_cnt=8'h00; rst mid-stream -> out_valid=0 the next cycle, and the next word decodes with SEED_DEFAULT.

Source files
------------

// File: rtl/xor_stream_descrambler.sv
// Additive descrambler: each accepted word is XORed with a 16-bit Fibonacci LFSR
// keystream (x^16+x^14+x^13+x^11+1). The output is a single register stage.
module xor_stream_descrambler #(
    parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        seed_load,
    input  logic [15:0] seed,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic [7:0]  word_cnt
);

    logic [15:0] r_lfsr;
    logic [15:0] r_out_data;
    logic        r_out_valid;
    logic [7:0]  r_word_cnt;

    logic        w_in_ready;
    logic        w_accept;
    logic        w_take;
    logic        w_fb;
    logic [15:0] w_lfsr_next;
    logic [15:0] w_seed_eff;

    // Handshake: a word moves on a side only in a cycle where valid && ready.
    // in_ready is combinational and is held low during a seed load, so a load
    // and an accept never coincide.
    assign w_in_ready  = !seed_load && (!r_out_valid || out_ready);
    assign w_accept    = in_valid && w_in_ready;
    assign w_take      = r_out_valid && out_ready;

    assign w_fb        = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_lfsr_next = {r_lfsr[14:0], w_fb};
    // A zero state would lock the LFSR, so a zero seed falls back to the default.
    assign w_seed_eff  = (seed == 16'h0000) ? SEED_DEFAULT : seed;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr     <= SEED_DEFAULT;
            r_word_cnt <= 8'h00;
        end else if (seed_load) begin
            r_lfsr     <= w_seed_eff;
            r_word_cnt <= 8'h00;
        end else if (w_accept) begin
            r_lfsr     <= w_lfsr_next;
            r_word_cnt <= r_word_cnt + 8'd1;
        end
    end

    // Output stage is independent of seed_load so a pending word survives a reseed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= 16'h0000;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= in_data ^ r_lfsr;
        end else if (w_take) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_xor_stream_descrambler.sv
// Directed bench for xor_stream_descrambler: hand-computed vectors plus a
// scoreboard that predicts every output word from its own LFSR model.
module tb_xor_stream_descrambler;

    logic        clk;
    logic        rst;
    logic        seed_load;
    logic [15:0] seed;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [7:0]  word_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] exp_q[$];
    logic [15:0] m_lfsr;

    xor_stream_descrambler #(.SEED_DEFAULT(16'hACE1)) dut (
        .clk       (clk),
        .rst       (rst),
        .seed_load (seed_load),
        .seed      (seed),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .word_cnt  (word_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic ordy);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
    endtask

    // scoreboard: predict on accept, compare on take
    always @(posedge clk) begin
        if (rst) begin
            m_lfsr = 16'hACE1;
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0)
                    check_eq("sb_unexpected_take", 32'd1, 32'd0);
                else
                    check_eq("sb_data", {16'h0, out_data}, {16'h0, exp_q.pop_front()});
            end
            if (seed_load)
                m_lfsr = (seed == 16'h0000) ? 16'hACE1 : seed;
            else if (in_valid && in_ready) begin
                exp_q.push_back(in_data ^ m_lfsr);
                m_lfsr = lfsr_next(m_lfsr);
            end
        end
    end

    initial begin
        rst = 1'b1;
        seed_load = 1'b0;
        seed = 16'h0000;
        drive(1'b0, 16'h0000, 1'b0);
        tick();
        tick();
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_out_data", {16'd0, out_data}, 32'h0000);
        check_eq("rst_word_cnt", {24'd0, word_cnt}, 32'd0);
        rst = 1'b0;
        #1;
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // first two words, back to back
        drive(1'b1, 16'hAAAA, 1'b1);
        tick();
        check_eq("w1_valid", {31'd0, out_valid}, 32'd1);
        check_eq("w1_data", {16'd0, out_data}, 32'h064B);
        check_eq("w1_cnt", {24'd0, word_cnt}, 32'd1);
        check_eq("w1_in_ready", {31'd0, in_ready}, 32'd1);
        drive(1'b1, 16'h00FF, 1'b1);
        tick();
        check_eq("w2_valid", {31'd0, out_valid}, 32'd1);
        check_eq("w2_data", {16'd0, out_data}, 32'h593C);
        check_eq("w2_cnt", {24'd0, word_cnt}, 32'd2);

        // stall: output holds, no accept, LFSR frozen at 16'hB387
        drive(1'b1, 16'h1234, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check_eq("stall_data", {16'd0, out_data}, 32'h593C);
            check_eq("stall_valid", {31'd0, out_valid}, 32'd1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check_eq("unstall_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check_eq("unstall_data", {16'd0, out_data}, 32'hA1B3);
        check_eq("unstall_cnt", {24'd0, word_cnt}, 32'd3);

        // drain with no new accept
        drive(1'b0, 16'h0000, 1'b1);
        tick();
        check_eq("drain_valid", {31'd0, out_valid}, 32'd0);

        // zero seed falls back to the default
        seed_load = 1'b1;
        seed = 16'h0000;
        drive(1'b1, 16'hFFFF, 1'b1);
        #1;
        check_eq("seed0_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        seed_load = 1'b0;
        check_eq("seed0_cnt", {24'd0, word_cnt}, 32'd0);
        check_eq("seed0_no_accept", {31'd0, out_valid}, 32'd0);
        drive(1'b1, 16'hAAAA, 1'b1);
        tick();
        check_eq("seed0_data", {16'd0, out_data}, 32'h064B);
        check_eq("seed0_w_cnt", {24'd0, word_cnt}, 32'd1);

        // reseed while a word is pending
        drive(1'b0, 16'h0000, 1'b0);
        tick();
        seed_load = 1'b1;
        seed = 16'h1234;
        drive(1'b1, 16'h5555, 1'b0);
        #1;
        check_eq("reseed_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        seed_load = 1'b0;
        check_eq("reseed_hold_data", {16'd0, out_data}, 32'h064B);
        check_eq("reseed_hold_valid", {31'd0, out_valid}, 32'd1);
        check_eq("reseed_cnt", {24'd0, word_cnt}, 32'd0);
        drive(1'b1, 16'h5555, 1'b1);
        tick();
        check_eq("reseed_data", {16'd0, out_data}, 32'h4761);
        check_eq("reseed_w_cnt", {24'd0, word_cnt}, 32'd1);

        // 256 accepts wrap the counter; data checked by the scoreboard
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 16'($urandom_range(0, 65535)), 1'b1);
            tick();
        end
        check_eq("wrap_cnt", {24'd0, word_cnt}, 32'd0);
        check_eq("wrap_valid", {31'd0, out_valid}, 32'd1);

        // reset mid-stream, with a competing seed load and accept
        rst = 1'b1;
        seed_load = 1'b1;
        seed = 16'h1234;
        tick();
        check_eq("midrst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("midrst_cnt", {24'd0, word_cnt}, 32'd0);
        rst = 1'b0;
        seed_load = 1'b0;
        drive(1'b1, 16'hAAAA, 1'b1);
        tick();
        check_eq("midrst_data", {16'd0, out_data}, 32'h064B);
        drive(1'b0, 16'h0000, 1'b1);
        tick();
        tick();
        check_eq("sb_queue_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
